apb_slave_regif: RTL and testbench
==================================

// Module: apb_slave_regif
// PURPOSE
//  APB4 completer bridging one APB port to a simple register-file backend.
//  Parametrised data/address width and address window. Registered pready/pslverr/prdata.
//  Adds backend ack handshake, address-window decode, alignment check and optional timeout.
//  Sits between the APB interconnect decoder and a peripheral's register bank.
// PARAMETERS
//  ADDR_WIDTH      12      paddr/reg_addr width
//  DATA_WIDTH      32      data width; legal values are 8, 16, 32 and 64; STRB_W=DATA_WIDTH/8
//  BASE_ADDR       0       window base, byte address
//  ADDR_RANGE      4096    window size in bytes; decode hits when BASE_ADDR <= paddr < BASE_ADDR+ADDR_RANGE
//  TIMEOUT_CYCLES  16      max WAIT cycles before forced error (only with APB_SLV_TIMEOUT_EN); >=1
// PORTS
//  pclk       in   1           clock
//  prst       in   1           synchronous reset, active-high
//  psel       in   1           APB select
//  penable    in   1           APB enable
//  pwrite     in   1           1=write, 0=read
//  paddr      in   ADDR_WIDTH  byte address
//  pwdata     in   DATA_WIDTH  write data
//  pstrb      in   STRB_W      write byte strobes
//  prdata     out  DATA_WIDTH  read data; registered
//  pready     out  1           transfer complete; registered
//  pslverr    out  1           error response; valid only while pready=1
//  reg_addr   out  ADDR_WIDTH  offset, paddr-BASE_ADDR
//  reg_wr     out  1           one-cycle write strobe
//  reg_rd     out  1           one-cycle read strobe
//  reg_wdata  out  DATA_WIDTH  pwdata pass-through
//  reg_strb   out  STRB_W      pstrb on writes; all-ones on reads
//  reg_rdata  in   DATA_WIDTH  backend read data; sampled when reg_ack=1
//  reg_ack    in   1           backend done; legal in the reg_rd/reg_wr cycle or later
//  reg_err    in   1           backend error; qualified by reg_ack
// BEHAVIOUR
//  Reset: state=IDLE; pready, pslverr, reg_wr and reg_rd are 0; prdata=0.
//    Reset applies from any state; an in-flight transfer is dropped without a response.
//  FSM states: IDLE, REQ, WAIT, RESP.
//  IDLE
//   - psel & !penable (setup phase) -> REQ.
//   - Latches decode error derr = out-of-window | (paddr[log2(STRB_W)-1:0] != 0).
//  REQ (first access cycle)
//   - derr=0: drive reg_wr=pwrite or reg_rd=!pwrite for exactly this cycle.
//       reg_ack=1 this cycle -> RESP; otherwise -> WAIT.
//   - derr=1: no backend strobe; -> RESP with err=1.
//  WAIT
//   - reg_ack=1 -> RESP.
//   - Timeout counter expires -> RESP, err=1, data=0.
//  Latch on completion
//   - On ack: err=reg_err; data=reg_rdata if read&!reg_err, else 0.
//  RESP
//   - pready=1, pslverr=err, prdata=data for exactly one cycle; -> IDLE.
//   - pready=0 in every other state.
//   - prdata returns to 0 in IDLE.
//  Latency: ack in REQ gives pready in the 2nd access cycle (1 wait state).
//    Each extra ack cycle adds 1 wait state.
//  Back-to-back: next setup may arrive in the cycle after RESP, no idle cycle required.
//  Abort: psel=0 or penable=0 while in REQ or WAIT -> IDLE, no pready.
//    reg_ack arriving in IDLE is ignored.
//  Address arithmetic: reg_addr=paddr-BASE_ADDR, truncated to ADDR_WIDTH.
//    Window compare is done at ADDR_WIDTH+1 bits so it cannot wrap.
//  pslverr writes: the backend must not have committed the write when reg_err=1.
//    Decode errors never strobe the backend.
// CONFIGURATION
//  APB_SLV_TIMEOUT_EN defined
//   - Counter clears on entry to WAIT and increments each WAIT cycle.
//   - Reaching TIMEOUT_CYCLES without ack forces RESP with pslverr=1 and prdata=0.
//  APB_SLV_TIMEOUT_EN undefined
//   - No counter; WAIT holds indefinitely until reg_ack.
// TESTING
//  Reset mid-WAIT -> next cycle IDLE, pready=0, prdata=0; a later reg_ack is ignored.
//  Write 0x010, pwdata=0xA5A5_0001, pstrb=4'b0011, ack in REQ
//    -> reg_wr 1 cycle, reg_addr=0x010, reg_strb=0011, pready 2nd access cycle, pslverr=0.
//  Read 0x020, ack after 3 WAIT cycles with reg_rdata=0xDEAD_BEEF
//    -> pready on the 5th access cycle, prdata=0xDEAD_BEEF, pslverr=0.
//  BASE_ADDR=0x100, ADDR_RANGE=0x100, read 0x200 or misaligned 0x102
//    -> no reg_rd, pready 2nd access cycle, pslverr=1, prdata=0.
//  Read with reg_ack and reg_err together -> pslverr=1, prdata=0.
//    Then a back-to-back write setup in the next cycle completes normally.
//  APB_SLV_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack
//    -> pready=1, pslverr=1 after 4 WAIT cycles; without the macro pready stays 0 for 100 cycles.

Source files
------------

// File: rtl/apb_slave_regif_if.sv
// APB4 bus bundle between the interconnect (master) and apb_slave_regif (slave).
interface apb_slave_regif_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regif.sv
// APB4 completer bridging one APB port to a register-file backend with ack handshake.
// Optional WAIT timeout enabled by defining APB_SLV_TIMEOUT_EN.
module apb_slave_regif #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BASE_ADDR      = 0,
  parameter int ADDR_RANGE     = 4096,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_W        = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  prst,
  apb_slave_regif_if.slave      apb,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr,
  output logic                  reg_rd,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]     reg_strb,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH+1:0] BASE_X     = (ADDR_WIDTH+2)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   RANGE_X    = (ADDR_WIDTH+1)'(ADDR_RANGE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  state_t                state;
  state_t                state_n;
  logic                  derr;
  logic                  access;
  logic                  timeout;
  logic                  out_of_win;
  logic                  misaligned;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [ADDR_WIDTH+1:0] addr_off;

  // Offset carries a borrow bit so addresses below the base cannot wrap into the window.
  assign addr_off   = {2'b00, apb.paddr} - BASE_X;
  assign out_of_win = addr_off[ADDR_WIDTH+1] || (addr_off[ADDR_WIDTH:0] >= RANGE_X);
  assign misaligned = |(apb.paddr & ALIGN_MASK);
  assign access     = apb.psel & apb.penable;

  assign reg_addr  = addr_off[ADDR_WIDTH-1:0];
  assign reg_wdata = apb.pwdata;
  assign reg_strb  = apb.pwrite ? apb.pstrb : '1;

`ifdef APB_SLV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge pclk) begin
    if (prst || state != WAIT) wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (prst) begin
      state       <= IDLE;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end else begin
      state       <= state_n;
      apb.pready  <= (state_n == RESP);
      apb.pslverr <= (state_n == RESP) & resp_err;
      apb.prdata  <= (state_n == RESP) ? resp_data : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (state == IDLE) derr <= out_of_win | misaligned;
  end

  always_comb begin
    state_n   = state;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state)
      IDLE: if (apb.psel && !apb.penable) state_n = REQ;
      REQ: begin
        if (!access) begin
          state_n = IDLE;
        end else if (derr) begin
          state_n  = RESP;
          resp_err = 1'b1;
        end else begin
          reg_wr = apb.pwrite & !prst;
          reg_rd = !apb.pwrite & !prst;
          if (reg_ack) begin
            state_n   = RESP;
            resp_err  = reg_err;
            resp_data = (!apb.pwrite && !reg_err) ? reg_rdata : '0;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!access) begin
          state_n = IDLE;
        end else if (reg_ack) begin
          state_n   = RESP;
          resp_err  = reg_err;
          resp_data = (!apb.pwrite && !reg_err) ? reg_rdata : '0;
        end else if (timeout) begin
          state_n  = RESP;
          resp_err = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_slave_regif.sv
// Directed bench: dut0 uses the full window at base 0, dut1 a 0x100-byte window at 0x100.
module tb_apb_slave_regif;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  apb_slave_regif_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) a ();
  apb_slave_regif_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b ();

  assign b.psel    = a.psel;
  assign b.penable = a.penable;
  assign b.pwrite  = a.pwrite;
  assign b.paddr   = a.paddr;
  assign b.pwdata  = a.pwdata;
  assign b.pstrb   = a.pstrb;

  logic [11:0] reg_addr0, reg_addr1;
  logic        reg_wr0, reg_rd0, reg_wr1, reg_rd1;
  logic [31:0] reg_wdata0, reg_wdata1;
  logic [3:0]  reg_strb0, reg_strb1;
  logic [31:0] reg_rdata;
  logic        reg_ack, reg_err;

  apb_slave_regif #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(0), .ADDR_RANGE(4096),
                    .TIMEOUT_CYCLES(4)) dut0 (
    .pclk(pclk), .prst(prst), .apb(a),
    .reg_addr(reg_addr0), .reg_wr(reg_wr0), .reg_rd(reg_rd0), .reg_wdata(reg_wdata0),
    .reg_strb(reg_strb0), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  apb_slave_regif #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BASE_ADDR(32'h100), .ADDR_RANGE(32'h100),
                    .TIMEOUT_CYCLES(16)) dut1 (
    .pclk(pclk), .prst(prst), .apb(b),
    .reg_addr(reg_addr1), .reg_wr(reg_wr1), .reg_rd(reg_rd1), .reg_wdata(reg_wdata1),
    .reg_strb(reg_strb1), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  int errors = 0;
  int checks = 0;

  int          lat0, lat1, nstb0, nstb1;
  logic [11:0] saddr0, saddr1;
  logic [3:0]  sstrb0;
  logic [31:0] swd0, rd0, rd1;
  logic        slv0, slv1;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One APB transfer; ack_at is the access-cycle index (0 = first) carrying reg_ack, -1 = never.
  // Leaves the bench at the cycle after RESP (or after limit access cycles) with psel low.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int ack_at, input logic [31:0] rdv,
                      input logic errv, input int limit);
    lat0 = 0; lat1 = 0; nstb0 = 0; nstb1 = 0; saddr0 = '0; saddr1 = '0; sstrb0 = '0;
    swd0 = '0; rd0 = '0; rd1 = '0; slv0 = 1'b0; slv1 = 1'b0;
    a.psel = 1'b1; a.penable = 1'b0; a.pwrite = wr; a.paddr = addr; a.pwdata = wd; a.pstrb = st;
    tick();
    a.penable = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      reg_ack = (c - 1 == ack_at); reg_err = errv; reg_rdata = rdv;
      #1;
      if (b.pready && lat1 == 0) begin lat1 = c; rd1 = b.prdata; slv1 = b.pslverr; end
      if (reg_wr1 || reg_rd1) begin nstb1++; saddr1 = reg_addr1; end
      if (a.pready) begin lat0 = c; rd0 = a.prdata; slv0 = a.pslverr; break; end
      if (reg_wr0 || reg_rd0) begin nstb0++; saddr0 = reg_addr0; sstrb0 = reg_strb0; swd0 = reg_wdata0; end
      tick();
    end
    if (lat0 != 0) tick();
    a.psel = 1'b0; a.penable = 1'b0; reg_ack = 1'b0; reg_err = 1'b0;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    repeat (3) tick();
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL rst_pready got=%b exp=0", a.pready); end
    checks++; if (a.pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr got=%b exp=0", a.pslverr); end
    checks++; if (a.prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata got=%h exp=0", a.prdata); end
    checks++; if ((reg_wr0 | reg_rd0) !== 1'b0) begin errors++; $display("FAIL rst_strobe got=%b exp=0", reg_wr0 | reg_rd0); end
    prst = 1'b0;
    tick();
    // Reset while a read sits in WAIT
    a.psel = 1'b1; a.penable = 1'b0; a.pwrite = 1'b0; a.paddr = 12'h020; a.pstrb = 4'hF;
    tick();
    a.penable = 1'b1;
    tick();
    tick();
    prst = 1'b1;
    tick();
    prst = 1'b0;
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL rstwait_pready got=%b exp=0", a.pready); end
    checks++; if (a.prdata !== 32'h0) begin errors++; $display("FAIL rstwait_prdata got=%h exp=0", a.prdata); end
    reg_ack = 1'b1; reg_rdata = 32'hFFFF_FFFF;
    tick();
    #1;
    checks++; if (reg_rd0 !== 1'b0) begin errors++; $display("FAIL rstwait_rd got=%b exp=0", reg_rd0); end
    tick();
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL rstwait_lateack got=%b exp=0", a.pready); end
    a.psel = 1'b0; a.penable = 1'b0; reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_write();
    xfer(1'b1, 12'h010, 32'hA5A5_0001, 4'b0011, 0, 32'h0, 1'b0, 20);
    checks++; if (lat0 !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat0); end
    checks++; if (nstb0 !== 1) begin errors++; $display("FAIL wr_strobes got=%0d exp=1", nstb0); end
    checks++; if (saddr0 !== 12'h010) begin errors++; $display("FAIL wr_addr got=%h exp=010", saddr0); end
    checks++; if (sstrb0 !== 4'b0011) begin errors++; $display("FAIL wr_strb got=%b exp=0011", sstrb0); end
    checks++; if (swd0 !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_wdata got=%h exp=a5a50001", swd0); end
    checks++; if (slv0 !== 1'b0) begin errors++; $display("FAIL wr_pslverr got=%b exp=0", slv0); end
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL wr_pready_after got=%b exp=0", a.pready); end
    checks++; if (nstb1 !== 0 || slv1 !== 1'b1) begin errors++; $display("FAIL wr_win1 got=%0d/%b exp=0/1", nstb1, slv1); end
    tick();
  endtask

  task automatic test_read_wait();
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0, 20);
    checks++; if (lat0 !== 5) begin errors++; $display("FAIL rd_latency got=%0d exp=5", lat0); end
    checks++; if (nstb0 !== 1) begin errors++; $display("FAIL rd_strobes got=%0d exp=1", nstb0); end
    checks++; if (saddr0 !== 12'h020) begin errors++; $display("FAIL rd_addr got=%h exp=020", saddr0); end
    checks++; if (sstrb0 !== 4'hF) begin errors++; $display("FAIL rd_strb got=%b exp=1111", sstrb0); end
    checks++; if (rd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_prdata got=%h exp=deadbeef", rd0); end
    checks++; if (slv0 !== 1'b0) begin errors++; $display("FAIL rd_pslverr got=%b exp=0", slv0); end
    checks++; if (a.prdata !== 32'h0) begin errors++; $display("FAIL rd_prdata_idle got=%h exp=0", a.prdata); end
    tick();
  endtask

  task automatic test_decode();
    xfer(1'b0, 12'h200, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 20);
    checks++; if (lat1 !== 2) begin errors++; $display("FAIL oow_latency got=%0d exp=2", lat1); end
    checks++; if (nstb1 !== 0) begin errors++; $display("FAIL oow_strobes got=%0d exp=0", nstb1); end
    checks++; if (slv1 !== 1'b1) begin errors++; $display("FAIL oow_pslverr got=%b exp=1", slv1); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL oow_prdata got=%h exp=0", rd1); end
    checks++; if (rd0 !== 32'h1234_5678) begin errors++; $display("FAIL win0_prdata got=%h exp=12345678", rd0); end
    tick();
    xfer(1'b0, 12'h102, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 20);
    checks++; if (lat1 !== 2) begin errors++; $display("FAIL mis_latency got=%0d exp=2", lat1); end
    checks++; if (nstb1 !== 0 || nstb0 !== 0) begin errors++; $display("FAIL mis_strobes got=%0d/%0d exp=0/0", nstb1, nstb0); end
    checks++; if (slv1 !== 1'b1 || slv0 !== 1'b1) begin errors++; $display("FAIL mis_pslverr got=%b/%b exp=1/1", slv1, slv0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL mis_prdata got=%h exp=0", rd1); end
    tick();
    xfer(1'b0, 12'h0FC, 32'h0, 4'h0, 0, 32'h0, 1'b0, 20);
    checks++; if (slv1 !== 1'b1 || nstb1 !== 0) begin errors++; $display("FAIL below_base got=%b/%0d exp=1/0", slv1, nstb1); end
    tick();
    xfer(1'b0, 12'h1FC, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 20);
    checks++; if (nstb1 !== 1) begin errors++; $display("FAIL top_strobes got=%0d exp=1", nstb1); end
    checks++; if (saddr1 !== 12'h0FC) begin errors++; $display("FAIL top_offset got=%h exp=0fc", saddr1); end
    checks++; if (lat1 !== 3) begin errors++; $display("FAIL top_latency got=%0d exp=3", lat1); end
    checks++; if (rd1 !== 32'hCAFE_F00D || slv1 !== 1'b0) begin errors++; $display("FAIL top_resp got=%h/%b exp=cafef00d/0", rd1, slv1); end
    tick();
  endtask

  task automatic test_back_to_back();
    xfer(1'b0, 12'h040, 32'h0, 4'h0, 0, 32'h55AA_55AA, 1'b1, 20);
    checks++; if (lat0 !== 2) begin errors++; $display("FAIL err_latency got=%0d exp=2", lat0); end
    checks++; if (slv0 !== 1'b1) begin errors++; $display("FAIL err_pslverr got=%b exp=1", slv0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL err_prdata got=%h exp=0", rd0); end
    xfer(1'b1, 12'h044, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0, 20);
    checks++; if (lat0 !== 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", lat0); end
    checks++; if (slv0 !== 1'b0) begin errors++; $display("FAIL b2b_pslverr got=%b exp=0", slv0); end
    checks++; if (nstb0 !== 1 || saddr0 !== 12'h044) begin errors++; $display("FAIL b2b_strobe got=%0d/%h exp=1/044", nstb0, saddr0); end
    tick();
  endtask

  task automatic test_abort();
    xfer(1'b1, 12'h050, 32'h0, 4'hF, -1, 32'h0, 1'b0, 2);
    checks++; if (lat0 !== 0 || nstb0 !== 1) begin errors++; $display("FAIL abort_pre got=%0d/%0d exp=0/1", lat0, nstb0); end
    tick();
    reg_ack = 1'b1;
    tick();
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL abort_ack1 got=%b exp=0", a.pready); end
    tick();
    checks++; if (a.pready !== 1'b0) begin errors++; $display("FAIL abort_ack2 got=%b exp=0", a.pready); end
    reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    xfer(1'b0, 12'h060, 32'h0, 4'h0, -1, 32'hBAD0_BAD0, 1'b0, 100);
`ifdef APB_SLV_TIMEOUT_EN
    checks++; if (lat0 !== 6) begin errors++; $display("FAIL tmo_latency got=%0d exp=6", lat0); end
    checks++; if (slv0 !== 1'b1) begin errors++; $display("FAIL tmo_pslverr got=%b exp=1", slv0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL tmo_prdata got=%h exp=0", rd0); end
`else
    checks++; if (lat0 !== 0) begin errors++; $display("FAIL notmo_pready got=%0d exp=0", lat0); end
    checks++; if (nstb0 !== 1) begin errors++; $display("FAIL notmo_strobes got=%0d exp=1", nstb0); end
`endif
    tick();
    tick();
  endtask

  initial begin
    a.psel = 1'b0; a.penable = 1'b0; a.pwrite = 1'b0; a.paddr = '0; a.pwdata = '0; a.pstrb = '0;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_decode();
    test_back_to_back();
    test_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
